sine_phase_gen: RTL and testbench

SINE_PHASE_GEN -- requirements
Module: sine_phase_gen

---
 rtl/sine_phase_gen.sv | 187 ++++++++++++++++++
 tb/tb_sine_phase_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_gen.sv
// sine_phase_gen: 8-bit phase accumulator driving a 16-entry quarter-wave
// sine ROM. Each sample is presented as a non-negative magnitude, its
// two's-complement negation and a sign select, so that a downstream 2:1 mux
// forms the signed sine value. Samples are handed over with valid/ready.
// Timing: en sampled in IDLE -> ROM address registered (ADDR) -> ROM data
// registered into the outputs (HOLD, valid = 1) -> held until the handshake.

module sine_phase_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  tune,
    input  logic        phase_ld,
    input  logic [7:0]  phase_in,
    output logic [15:0] pos_sample,
    output logic [15:0] neg_sample,
    output logic        sel,
    output logic        valid,
    input  logic        ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Phase accumulator: [7:6] quadrant, [5:2] ROM index, [1:0] fractional.
    logic [7:0]  phase;
    logic [7:0]  phase_adv;

    // Address and sign captured one cycle ahead of the ROM read.
    logic [3:0]  rom_addr;
    logic        sel_pend;
    logic [15:0] rom_data;

    // FSM control strobes.
    logic        do_load;
    logic        do_start;
    logic        do_emit;
    logic        do_hs;

    // Quadrants 1 and 3 walk the quarter wave backwards; 15 - i is ~i in
    // four bits. Argument is phase[6:2]: the low quadrant bit plus index.
    function automatic logic [3:0] rom_addr_of(input logic [4:0] qi);
        rom_addr_of = qi[4] ? ~qi[3:0] : qi[3:0];
    endfunction

    assign phase_adv = phase + tune;

    // Quarter-wave ROM: round(32767 * sin(pi * (k + 0.5) / 32)), k = 0..15.
    // Half-step offset keeps every entry non-zero and symmetric about the
    // quadrant boundary, so mirrored addressing needs no special cases.
    always_comb begin
        rom_data = 16'd0;
        case (rom_addr)
            4'd0:  rom_data = 16'd1608;
            4'd1:  rom_data = 16'd4808;
            4'd2:  rom_data = 16'd7962;
            4'd3:  rom_data = 16'd11039;
            4'd4:  rom_data = 16'd14010;
            4'd5:  rom_data = 16'd16846;
            4'd6:  rom_data = 16'd19519;
            4'd7:  rom_data = 16'd22005;
            4'd8:  rom_data = 16'd24279;
            4'd9:  rom_data = 16'd26319;
            4'd10: rom_data = 16'd28105;
            4'd11: rom_data = 16'd29621;
            4'd12: rom_data = 16'd30852;
            4'd13: rom_data = 16'd31785;
            4'd14: rom_data = 16'd32412;
            4'd15: rom_data = 16'd32728;
            default: rom_data = 16'd0;
        endcase
    end

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A phase load in IDLE blocks a start in the same
    // cycle; once a sample is under way it always completes via HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!phase_ld && en) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (ready) begin
                    state_nxt = en ? ADDR : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control strobes decoded from the current state and inputs.
    always_comb begin
        do_load  = 1'b0;
        do_start = 1'b0;
        do_emit  = 1'b0;
        do_hs    = 1'b0;
        case (state)
            IDLE: begin
                do_load  = phase_ld;
                do_start = !phase_ld && en;
            end
            ADDR: begin
                do_emit  = 1'b1;
            end
            HOLD: begin
                do_hs    = ready;
            end
            default: begin
                do_load  = 1'b0;
            end
        endcase
    end

    // Phase accumulator: loaded only in IDLE, advanced only on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 8'd0;
        end else if (do_load) begin
            phase <= phase_in;
        end else if (do_hs) begin
            phase <= phase_adv;
        end
    end

    // Address/sign pipeline stage. After a handshake the address is taken
    // from the advanced phase so back-to-back samples need no IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= 4'd0;
            sel_pend <= 1'b0;
        end else if (do_start) begin
            rom_addr <= rom_addr_of(phase[6:2]);
            sel_pend <= phase[7];
        end else if (do_hs) begin
            rom_addr <= rom_addr_of(phase_adv[6:2]);
            sel_pend <= phase_adv[7];
        end
    end

    // Output stage: captured from the ROM in ADDR, frozen through HOLD so
    // the mux inputs stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_sample <= 16'd0;
            neg_sample <= 16'd0;
            sel        <= 1'b0;
        end else if (do_emit) begin
            pos_sample <= rom_data;
            neg_sample <= 16'd0 - rom_data;
            sel        <= sel_pend;
        end
    end

    // Valid flag: raised when a sample lands, dropped on its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (do_emit) begin
            valid <= 1'b1;
        end else if (do_hs) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sine_phase_gen.sv
// Bench for sine_phase_gen: a phase/sample model (sine computed with $sin)
// checked on every cycle, plus directed scenarios with literal expectations.

module tb_sine_phase_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  tune = 8'd0;
    logic        phase_ld = 1'b0;
    logic [7:0]  phase_in = 8'd0;
    logic        ready = 1'b0;
    logic [15:0] pos_sample;
    logic [15:0] neg_sample;
    logic        sel;
    logic        valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: expected phase = base_phase + k_samp * tune (mod 256).
    // base_phase is set by the stimulus (reset / load), k_samp counts
    // completed handshakes and is owned by the compare process.
    logic [7:0] base_phase = 8'd0;
    int         k_samp = 0;

    sine_phase_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tune       (tune),
        .phase_ld   (phase_ld),
        .phase_in   (phase_in),
        .pos_sample (pos_sample),
        .neg_sample (neg_sample),
        .sel        (sel),
        .valid      (valid),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lut(input int k);
        real pi;
        pi = 3.14159265358979;
        return $rtoi(32767.0 * $sin(pi * (real'(k) + 0.5) / 32.0) + 0.5);
    endfunction

    // Sine magnitude for a phase: quadrants 1 and 3 run the table backwards.
    function automatic int model_pos(input logic [7:0] ph);
        int q;
        int i;
        q = int'(ph[7:6]);
        i = int'(ph[5:2]);
        if (q == 1 || q == 3) return lut(15 - i);
        return lut(i);
    endfunction

    function automatic int model_sel(input logic [7:0] ph);
        return (ph >= 8'd128) ? 1 : 0;
    endfunction

    // Per-cycle compare against the model; also advances the model.
    always @(negedge clk) begin
        logic [7:0]  ph;
        logic [15:0] nexp;
        ph   = base_phase + 8'(k_samp * int'(tune));
        nexp = 16'd0 - pos_sample;
        check("neg_eq_minus_pos", int'(neg_sample), int'(nexp));
        if (valid) begin
            check("model_pos", int'(pos_sample), model_pos(ph));
            check("model_sel", int'(sel), model_sel(ph));
        end
        if (rst) k_samp = 0;
        else if (valid && ready) k_samp++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        ready = 1'b0;
        phase_ld = 1'b0;
        cyc();
        base_phase = 8'd0;
        cyc();
    endtask

    task automatic wait_valid(input string name, input int maxc);
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (valid) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    int a_pos[5];
    int a_sel[5];
    int a_neg[5];
    int e_pos[5] = '{1608, 32728, 1608, 32728, 1608};
    int e_sel[5] = '{0, 0, 1, 1, 0};
    int e_neg[5] = '{16'hF9B8, 16'h8028, 16'hF9B8, 16'h8028, 16'hF9B8};

    initial begin
        int got;

        // Model pins against hand-computed table values.
        check("lut0", lut(0), 1608);
        check("lut8", lut(8), 24279);
        check("lut15", lut(15), 32728);

        // Reset state.
        do_reset();
        check("rst_valid", int'(valid), 0);
        check("rst_pos", int'(pos_sample), 0);
        check("rst_neg", int'(neg_sample), 0);
        check("rst_sel", int'(sel), 0);

        // Free-running, tune = 64: one sample per quadrant, then wrap.
        rst = 1'b0; en = 1'b1; ready = 1'b1; tune = 8'd64;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (valid && ready) begin
                a_pos[got] = int'(pos_sample);
                a_sel[got] = int'(sel);
                a_neg[got] = int'(neg_sample);
                got++;
            end
        end
        check("seq_count", got, 5);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("seq%0d_pos", s), a_pos[s], e_pos[s]);
            check($sformatf("seq%0d_sel", s), a_sel[s], e_sel[s]);
            check($sformatf("seq%0d_neg", s), a_neg[s], e_neg[s]);
        end

        // Stall: ready low for 10 cycles, phase_ld ignored while busy.
        do_reset();
        rst = 1'b0; en = 1'b1; ready = 1'b0; tune = 8'd16;
        cyc();
        phase_ld = 1'b1; phase_in = 8'hC0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("stall_c1_valid", int'(valid), 0);
            end else begin
                check($sformatf("stall_c%0d_valid", c), int'(valid), 1);
                check($sformatf("stall_c%0d_pos", c), int'(pos_sample), 1608);
                check($sformatf("stall_c%0d_sel", c), int'(sel), 0);
            end
        end
        @(posedge clk); #1;
        ready = 1'b1; phase_ld = 1'b0;
        @(negedge clk);
        check("stall_hs_valid", int'(valid), 1);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        check("stall_after_hs_valid", int'(valid), 0);
        @(negedge clk);
        check("stall_next_valid", int'(valid), 1);
        check("stall_next_pos", int'(pos_sample), 14010);

        // Load in IDLE with en high: no start that cycle.
        do_reset();
        rst = 1'b0; phase_ld = 1'b1; phase_in = 8'h3C; en = 1'b1;
        base_phase = 8'h3C; tune = 8'd0;
        cyc();
        phase_ld = 1'b0;
        @(negedge clk);
        check("ld_c1_valid", int'(valid), 0);
        @(negedge clk);
        check("ld_c2_valid", int'(valid), 0);
        @(negedge clk);
        check("ld_c3_valid", int'(valid), 1);
        check("ld_pos", int'(pos_sample), 32728);
        check("ld_sel", int'(sel), 0);

        // tune = 0: eight identical samples from phase 0x9A.
        do_reset();
        rst = 1'b0; phase_ld = 1'b1; phase_in = 8'h9A; en = 1'b0; ready = 1'b1;
        base_phase = 8'h9A;
        cyc();
        phase_ld = 1'b0; en = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (valid && ready) begin
                check($sformatf("t0_s%0d_pos", got), int'(pos_sample), 19519);
                check($sformatf("t0_s%0d_sel", got), int'(sel), 1);
                got++;
            end
        end
        check("t0_count", got, 8);

        // Reset in HOLD with ready high: no handshake, phase not advanced.
        do_reset();
        rst = 1'b0; en = 1'b1; ready = 1'b0; tune = 8'd64;
        wait_valid("hold_rst_first", 10);
        @(posedge clk); #1;
        rst = 1'b1; ready = 1'b1;
        cyc();
        check("hold_rst_valid", int'(valid), 0);
        check("hold_rst_pos", int'(pos_sample), 0);
        check("hold_rst_neg", int'(neg_sample), 0);
        check("hold_rst_sel", int'(sel), 0);
        rst = 1'b0;
        wait_valid("hold_rst_next", 10);
        check("hold_rst_next_pos", int'(pos_sample), 1608);
        check("hold_rst_next_sel", int'(sel), 0);

        // en dropped in ADDR: sample still completes, then back to IDLE.
        do_reset();
        rst = 1'b0; en = 1'b1; ready = 1'b0; tune = 8'd32;
        cyc();
        en = 1'b0;
        @(negedge clk);
        check("endrop_c1_valid", int'(valid), 0);
        @(negedge clk);
        check("endrop_c2_valid", int'(valid), 1);
        check("endrop_pos", int'(pos_sample), 1608);
        @(posedge clk); #1;
        ready = 1'b1;
        @(negedge clk);
        check("endrop_hs_valid", int'(valid), 1);
        @(posedge clk); #1;
        ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("endrop_idle%0d_valid", c), int'(valid), 0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        wait_valid("endrop_restart", 10);
        check("endrop_restart_pos", int'(pos_sample), 24279);
        check("endrop_restart_sel", int'(sel), 0);

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
